// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The state enum, counter width and error-response word live here.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam int DEPTHI_DFLT = 8;
  localparam int CNT_W       = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic int words_of(input int depthi);
    return 2 ** (depthi - 2);
  endfunction

  localparam int WORDS = words_of(DEPTHI_DFLT);

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: writes land on the clock edge; reads are combinational, so same-cycle writes return old data.
// Backpressure: none; a write is accepted on every cycle with we high.
module imem_array
  import imem_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    WORDS     = imem_pkg::WORDS,
  parameter int    AW        = $clog2(WORDS),
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one request, answers LATENCY+1 cycles later, holds the response until rsp_ready.
// req_ready is low from acceptance until the response handshake, so requests never overlap.
module imem_responder
  import imem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTHI  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DEPTHI-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              prog_we,
  input  logic [DEPTHI-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  output logic              busy
);

  localparam int NWORDS = words_of(DEPTHI);
  localparam int AW     = DEPTHI - 2;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  imem_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DEPTHI-1:0] addr_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_err_q;
  logic [AW-1:0]     rd_idx;
  logic              rd_mis;
  logic [WIDTH-1:0]  rd_word;
  logic              accept;
  logic              load_rsp;
  logic              unused_prog_lsb;

  assign unused_prog_lsb = ^prog_addr[1:0];

  // With zero wait states the response is captured on the acceptance edge,
  // before addr_q holds the address, so read straight from the request.
  assign rd_idx   = (state == IDLE) ? req_addr[DEPTHI-1:2] : addr_q[DEPTHI-1:2];
  assign rd_mis   = (state == IDLE) ? (req_addr[1:0] != 2'b00) : (addr_q[1:0] != 2'b00);
  assign accept   = (state == IDLE) && req_valid;
  assign load_rsp = (state != RESP) && (state_nxt == RESP);

  imem_array #(
    .WIDTH (WIDTH),
    .WORDS (NWORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr[DEPTHI-1:2]),
    .wdata (prog_data),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (load_rsp) begin
        rsp_data_q <= rd_mis ? WIDTH'(NOP_WORD) : rd_word;
        rsp_err_q  <= rd_mis;
      end
    end
  end

  always_comb begin
    req_ready = rst && (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Checks a 2-wait-state and a 0-wait-state responder against a cycle-counting reference model
// plus hand-computed literal expectations for latency, data, errors, stalls and reset.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic [7:0]  req_addr  [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        rsp_ready [2];
  logic        prog_we   [2];
  logic [7:0]  prog_addr [2];
  logic [31:0] prog_data [2];
  logic        busy      [2];

  int n_cmp = 0;
  int n_bad = 0;

  imem_responder #(.WIDTH(32), .DEPTHI(8), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .rsp_ready(rsp_ready[0]),
    .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]),
    .busy(busy[0])
  );

  imem_responder #(.WIDTH(32), .DEPTHI(8), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .rsp_ready(rsp_ready[1]),
    .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted at cycle c answers in cycle c+LAT+1 with the word
  // as it stood before the edge ending cycle c+LAT, and stays up until rsp_ready is seen.
  logic [31:0] mmem  [2][64];
  logic        pend  [2];
  logic        vis   [2];
  int          acc   [2];
  logic [7:0]  eaddr [2];
  logic [31:0] edata [2];
  logic        eerr  [2];
  int          cyc = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; vis[k] = 1'b0; acc[k] = 0; eaddr[k] = '0; edata[k] = '0; eerr[k] = 1'b0;
      for (int w = 0; w < 64; w++) mmem[k][w] = '0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          pend[k] = 1'b0;
          vis[k]  = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (vis[k] && rsp_ready[k]) begin
            vis[k] = 1'b0;
          end else if (!pend[k] && !vis[k] && req_valid[k]) begin
            pend[k]  = 1'b1;
            acc[k]   = cyc;
            eaddr[k] = req_addr[k];
          end
          if (pend[k] && cyc == acc[k] + lat_of(k)) begin
            pend[k]  = 1'b0;
            vis[k]   = 1'b1;
            eerr[k]  = (eaddr[k] % 4) != 0;
            edata[k] = eerr[k] ? 32'h0 : mmem[k][eaddr[k] / 4];
          end
          if (prog_we[k]) mmem[k][prog_addr[k] / 4] = prog_data[k];
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          chk($sformatf("rst_valid%0d", k), 32'(rsp_valid[k]), 32'h0);
          chk($sformatf("rst_data%0d", k), rsp_data[k], 32'h0);
          chk($sformatf("rst_err%0d", k), 32'(rsp_err[k]), 32'h0);
          chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'h0);
          chk($sformatf("rst_ready%0d", k), 32'(req_ready[k]), 32'h0);
        end else begin
          chk($sformatf("m_valid%0d", k), 32'(rsp_valid[k]), 32'(vis[k]));
          chk($sformatf("m_busy%0d", k), 32'(busy[k]), 32'(pend[k] || vis[k]));
          chk($sformatf("m_ready%0d", k), 32'(req_ready[k]), 32'(!(pend[k] || vis[k])));
          if (vis[k]) begin
            chk($sformatf("m_data%0d", k), rsp_data[k], edata[k]);
            chk($sformatf("m_err%0d", k), 32'(rsp_err[k]), 32'(eerr[k]));
          end
        end
      end
    end
  end

  task automatic prog(input int k, input logic [7:0] a, input logic [31:0] d);
    prog_we[k] = 1'b1; prog_addr[k] = a; prog_data[k] = d;
    @(posedge clk); #1;
    prog_we[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    int g = 0;
    @(negedge clk);
    while (!req_ready[k] && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("accept_timeout", 32'(g < 20), 32'h1);
  endtask

  // Entered just after a rising edge; leaves just after the handshake edge (rsp_ready high)
  // or, with rsp_ready low, just after the edge ending the first response cycle.
  task automatic do_req(input int k, input logic [7:0] a, input logic [31:0] xd,
                        input logic xe, input int lat);
    int n = 0;
    req_valid[k] = 1'b1; req_addr[k] = a;
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[k] && n < 40);
    chk($sformatf("lat_%h", a), n, lat + 1);
    chk($sformatf("data_%h", a), rsp_data[k], xd);
    chk($sformatf("err_%h", a), 32'(rsp_err[k]), 32'(xe));
    @(posedge clk); #1;
  endtask

  logic [7:0]  b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
      prog_we[k] = 1'b0; prog_addr[k] = '0; prog_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready[0]), 32'h1);
    @(posedge clk); #1;

    prog(0, 8'h10, 32'h8C22_0004);
    prog(0, 8'h14, 32'h0043_0820);
    prog(0, 8'h20, 32'h1111_1111);
    prog(0, 8'h00, 32'hA5A5_0001);

    do_req(0, 8'h10, 32'h8C22_0004, 1'b0, 2);
    do_req(0, 8'h14, 32'h0043_0820, 1'b0, 2);
    do_req(0, 8'h12, 32'h0000_0000, 1'b1, 2);

    // Response stall: a competing request must not be taken while the response waits.
    rsp_ready[0] = 1'b0;
    do_req(0, 8'h14, 32'h0043_0820, 1'b0, 2);
    req_valid[0] = 1'b1; req_addr[0] = 8'h10;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[0]), 32'h1);
      chk("stall_data", rsp_data[0], 32'h0043_0820);
      chk("stall_ready", 32'(req_ready[0]), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("stall_last_valid", 32'(rsp_valid[0]), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_hs", 32'(req_ready[0]), 32'h1);
    chk("busy_after_hs", 32'(busy[0]), 32'h0);
    @(posedge clk); #1;

    // Write to the word being read on the edge that raises rsp_valid: old word returned.
    req_valid[0] = 1'b1; req_addr[0] = 8'h20;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    prog_we[0] = 1'b1; prog_addr[0] = 8'h20; prog_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rbw_not_yet", 32'(rsp_valid[0]), 32'h0);
    @(posedge clk); #1;
    prog_we[0] = 1'b0;
    @(negedge clk);
    chk("rbw_valid", 32'(rsp_valid[0]), 32'h1);
    chk("rbw_old", rsp_data[0], 32'h1111_1111);
    @(posedge clk); #1;
    do_req(0, 8'h20, 32'hDEAD_BEEF, 1'b0, 2);

    // Asynchronous reset while waiting.
    req_valid[0] = 1'b1; req_addr[0] = 8'h00;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy[0]), 32'h0);
    chk("arst_valid", 32'(rsp_valid[0]), 32'h0);
    chk("arst_ready", 32'(req_ready[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_arst", 32'(req_ready[0]), 32'h1);
    @(posedge clk); #1;
    do_req(0, 8'h00, 32'hA5A5_0001, 1'b0, 2);
    do_req(0, 8'h10, 32'h8C22_0004, 1'b0, 2);

    // Zero wait states: back-to-back requests, one accept every two cycles.
    prog(1, 8'h00, 32'h0000_0A00);
    prog(1, 8'h04, 32'h0000_0B04);
    prog(1, 8'hFC, 32'hCAFE_00FC);
    b2b_addr[0] = 8'h00; b2b_addr[1] = 8'h04; b2b_addr[2] = 8'hFC;
    b2b_data[0] = 32'h0000_0A00; b2b_data[1] = 32'h0000_0B04; b2b_data[2] = 32'hCAFE_00FC;
    req_valid[1] = 1'b1; req_addr[1] = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready[1]), 32'h1);
      @(posedge clk); #1;
      if (i < 2) req_addr[1] = b2b_addr[i+1];
      else req_valid[1] = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 32'(rsp_valid[1]), 32'h1);
      chk("b2b_data", rsp_data[1], b2b_data[i]);
      chk("b2b_busy_ready", 32'(req_ready[1]), 32'h0);
      @(posedge clk); #1;
    end
    do_req(1, 8'h02, 32'h0000_0000, 1'b1, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
